// File: rtl/mine_input_ctrl.sv
// -----------------------------------------------------------------------------
// mine_input_ctrl
//
// Upstream input stage for the minesweeper display/controller path.
// The five raw board push-buttons are synchronised (two flops each) and
// debounced. Clean rising edges move a cursor one block at a time on a
// GRID x GRID board. A middle-button press raises a held selection request
// toward the processor, which the processor clears with sel_ack.
//
// Build option:
//   MINE_CURSOR_WRAP_EN  - when defined, cursor moves wrap around the board
//                          edges instead of saturating.
//
// Parameters:
//   GRID       board dimension in blocks per side (2..8)
//   DB_CYCLES  consecutive stable clk cycles needed to accept a level change
//   DBW        debounce counter width (derived)
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   btn_up/btn_down/btn_left/btn_right/btn_middle
//               raw asynchronous push-buttons
//   sel_ack     processor acknowledge of the pending selection (level)
//   cursor_x    cursor column, 0..GRID-1
//   cursor_y    cursor row, 0..GRID-1
//   cursor_id   cursor_y*GRID + cursor_x, zero-extended
//   sel_valid   a selection is pending
//   sel_id      block id latched at the press, frozen while sel_valid is high
//   move_pulse  one-cycle strobe on any cursor position change
// -----------------------------------------------------------------------------
module mine_input_ctrl #(
  parameter int GRID      = 5,
  parameter int DB_CYCLES = 500000,
  parameter int DBW       = $clog2(DB_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_middle,
  input  logic        sel_ack,
  output logic [2:0]  cursor_x,
  output logic [2:0]  cursor_y,
  output logic [31:0] cursor_id,
  output logic        sel_valid,
  output logic [31:0] sel_id,
  output logic        move_pulse
);

  // Button lane assignment inside the packed vectors.
  localparam int NB      = 5;
  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_MID   = 4;

  localparam logic [2:0]     MAX_POS = 3'(GRID - 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  typedef enum logic [0:0] {
    SEL_IDLE = 1'b0,
    SEL_PEND = 1'b1
  } sel_state_t;

  logic [NB-1:0] raw_s;
  logic [NB-1:0] sync1_r;
  logic [NB-1:0] sync2_r;
  logic [NB-1:0] stable_s;
  logic [NB-1:0] stable_d_r;
  logic [NB-1:0] rise_r;

  logic [2:0]  nx_s;
  logic [2:0]  ny_s;
  logic [31:0] nid_s;
  logic        moved_s;

  sel_state_t  state_r;
  sel_state_t  state_s;
  logic        sel_load_s;

  assign raw_s = {btn_middle, btn_right, btn_left, btn_down, btn_up};

  // One-axis step: inc/dec are the two opposing edges on that axis.
  // Opposing edges cancel; the board edge either saturates or wraps.
  function automatic logic [2:0] axis_step(input logic [2:0] pos,
                                           input logic       inc,
                                           input logic       dec);
    logic [2:0] res;
    res = pos;
    case ({inc, dec})
      2'b10: begin
        if (pos == MAX_POS) begin
`ifdef MINE_CURSOR_WRAP_EN
          res = 3'd0;
`else
          res = pos;
`endif
        end else begin
          res = pos + 3'd1;
        end
      end
      2'b01: begin
        if (pos == 3'd0) begin
`ifdef MINE_CURSOR_WRAP_EN
          res = MAX_POS;
`else
          res = pos;
`endif
        end else begin
          res = pos - 3'd1;
        end
      end
      default: res = pos;
    endcase
    return res;
  endfunction

  // Two-flop synchroniser for all five raw buttons.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= {NB{1'b0}};
      sync2_r <= {NB{1'b0}};
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_db
    logic [DBW-1:0] cnt_r;
    logic           stb_r;

    // Debounce: accept the synchronised level only after it has differed
    // from the accepted level for DB_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt_r <= {DBW{1'b0}};
        stb_r <= 1'b0;
      end else if (sync2_r[i] != stb_r) begin
        if (cnt_r == DB_LAST) begin
          stb_r <= sync2_r[i];
          cnt_r <= {DBW{1'b0}};
        end else begin
          cnt_r <= cnt_r + DBW'(1);
        end
      end else begin
        cnt_r <= {DBW{1'b0}};
      end
    end

    assign stable_s[i] = stb_r;
  end

  // Registered rising-edge detect on the debounced levels; holding a
  // button therefore yields exactly one edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable_d_r <= {NB{1'b0}};
      rise_r     <= {NB{1'b0}};
    end else begin
      stable_d_r <= stable_s;
      rise_r     <= stable_s & ~stable_d_r;
    end
  end

  // Next cursor position and id from this cycle's edges.
  always_comb begin
    nx_s    = axis_step(cursor_x, rise_r[B_RIGHT], rise_r[B_LEFT]);
    ny_s    = axis_step(cursor_y, rise_r[B_DOWN],  rise_r[B_UP]);
    nid_s   = 32'(ny_s) * 32'(GRID) + 32'(nx_s);
    moved_s = (nx_s != cursor_x) || (ny_s != cursor_y);
  end

  // Cursor position, id and move strobe all register together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor_x   <= 3'd0;
      cursor_y   <= 3'd0;
      cursor_id  <= 32'd0;
      move_pulse <= 1'b0;
    end else begin
      cursor_x   <= nx_s;
      cursor_y   <= ny_s;
      cursor_id  <= nid_s;
      move_pulse <= moved_s;
    end
  end

  // Selection handshake next-state. An ack in PEND always wins, so a
  // middle press coinciding with it is dropped.
  always_comb begin
    state_s    = state_r;
    sel_load_s = 1'b0;
    case (state_r)
      SEL_IDLE: begin
        if (rise_r[B_MID]) begin
          state_s    = SEL_PEND;
          sel_load_s = 1'b1;
        end else begin
          state_s = SEL_IDLE;
        end
      end
      SEL_PEND: begin
        if (sel_ack) begin
          state_s = SEL_IDLE;
        end else begin
          state_s = SEL_PEND;
        end
      end
      default: begin
        state_s = SEL_IDLE;
      end
    endcase
  end

  // Selection state, registered valid flag and latched id. The id taken
  // is the post-move id so a move landing with the press is included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= SEL_IDLE;
      sel_valid <= 1'b0;
      sel_id    <= 32'd0;
    end else begin
      state_r   <= state_s;
      sel_valid <= (state_s == SEL_PEND);
      if (sel_load_s) begin
        sel_id <= nid_s;
      end
    end
  end

endmodule

// File: doc/mine_input_ctrl.md
Name: mine_input_ctrl

Overview:
- Upstream input stage for the minesweeper display/controller path.
- Takes the five raw board push-buttons and synchronises and debounces them.
- Turns clean presses into single-step cursor moves on the GRID x GRID board, and publishes the cursor block id.
- Raises a held "block selected" request toward the processor, which the processor acknowledges.

Parameters:
- GRID, 5, board dimension in blocks per side; legal range 2..8.
- DB_CYCLES, 500000, consecutive stable clk cycles required to accept a button level change (10 ms at 50 MHz).
- DBW, $clog2(DB_CYCLES+1), debounce counter width (derived).

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- btn_up  in  1  raw asynchronous button.
- btn_down  in  1  raw asynchronous button.
- btn_left  in  1  raw asynchronous button.
- btn_right  in  1  raw asynchronous button.
- btn_middle  in  1  raw asynchronous button.
- sel_ack  in  1  processor acknowledge of the pending selection; level, sampled each clk.
- cursor_x  out  3  cursor column, 0..GRID-1.
- cursor_y  out  3  cursor row, 0..GRID-1.
- cursor_id  out  32  cursor_y*GRID + cursor_x, zero-extended.
- sel_valid  out  1  a selection is pending.
- sel_id  out  32  block id latched at the press; held while sel_valid is high.
- move_pulse  out  1  one-cycle strobe on any cursor position change.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - all synchroniser flops, debounced levels and counters to 0;
  - cursor_x = cursor_y = 0, cursor_id = 0;
  - sel_valid = 0, sel_id = 0, move_pulse = 0.
- Reset release is synchronous to clk. Reset mid-debounce or mid-handshake discards all state.
- Synchroniser: each button passes through 2 flops; its output is sync_b.
- Debounce, per button:
  - The counter increments while sync_b != stable_b and clears to 0 whenever sync_b == stable_b.
  - When the counter reaches DB_CYCLES-1 while still differing, stable_b <= sync_b and the counter clears.
  - A glitch shorter than DB_CYCLES cycles never changes stable_b.
- Edge detect: rise_b = stable_b & ~stable_b_d (one cycle). Only rising edges act. Holding a button produces no repeat.
- Cursor update, on the clk after rise_*:
  - dx = rise_right - rise_left; dy = rise_down - rise_up.
  - Opposing edges in the same cycle cancel (dx or dy = 0).
  - Diagonal moves (one x edge and one y edge together) apply both axes.
  - Boundaries saturate: left at x=0 stays 0; right at x=GRID-1 stays GRID-1; the same applies to y.
  - move_pulse = 1 for exactly the cycle the registered position changes; 0 for saturated or cancelled moves.
- cursor_id is registered and updated in the same cycle as cursor_x and cursor_y. Its arithmetic is unsigned, with no overflow for GRID <= 8.
- Selection handshake, two states:
  - IDLE: sel_valid=0. On rise_middle, go to PEND; sel_id <= cursor_id as of that cycle, including a move landing the same cycle.
  - PEND: sel_valid=1 and sel_id is frozen. rise_middle is ignored. Cursor moves continue and do not alter sel_id. On sel_ack=1, go to IDLE next cycle.
  - sel_ack while IDLE is ignored.
  - rise_middle and sel_ack in the same cycle while in PEND: the ack wins, and that press is dropped.
- Latency: a raw level held constant reaches stable_b after 2 + DB_CYCLES cycles. Cursor, sel_valid and move_pulse update 2 cycles after that (edge detect + register).

Optional Feature:
- Macro: MINE_CURSOR_WRAP_EN.
- Defined: cursor moves wrap around instead of saturating.
  - Left at x=0 goes to GRID-1; right at GRID-1 goes to 0; y behaves the same way.
  - move_pulse asserts on every wrap.
- Undefined: saturating behaviour as above. No wrap logic is synthesised.

Test Plan (DB_CYCLES=4, GRID=5):
- Reset low mid-run with cursor at (3,2) and sel_valid=1 -> all outputs 0 within the same cycle; after release, cursor (0,0) and cursor_id=0.
- btn_right high 3 cycles then low, repeated -> cursor stays (0,0) and move_pulse never fires; btn_right held 20 cycles -> cursor (1,0), cursor_id=1, exactly one move_pulse, no repeat.
- From (4,4), clean presses of right and down -> stays (4,4) with move_pulse=0; with MINE_CURSOR_WRAP_EN -> right gives (0,4), then down gives (0,0), and move_pulse fires for each.
- Cursor at (2,3), clean middle press -> sel_valid=1 and sel_id=17. Then move left to (1,3) -> sel_id stays 17 while cursor_id=16. A second middle press -> ignored. sel_ack for 1 cycle -> sel_valid=0 next cycle.
- Clean left and right edges in the same cycle at (2,2) -> no move, move_pulse=0. Clean up+right together -> (3,1), cursor_id=8.
- sel_valid=1 with rise_middle and sel_ack coincident -> next cycle sel_valid=0 and sel_id unchanged; a later clean press latches the new cursor_id.
